ex_muldiv: RTL and testbench

Multi-cycle HI/LO arithmetic unit in the execute stage, downstream of the R-type decoder. Consumes the 8-bit decoded `INST_*` code (from `defs.v`) for the multiply, divide, multiply-accumulate and HI/LO-move instructions, plus the two register-file operands. Owns the architectural HI and LO registers. Asserts `busy` so the pipeline stalls while an operation is in flight.

---
 rtl/ex_muldiv.sv | 193 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Execute-stage HI/LO unit: multi-cycle multiply/MAC, restoring divide and HI/LO moves.
// Owns the architectural HI/LO registers and stalls the pipeline through busy.
module ex_muldiv #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  inst,
  input  logic        op_valid,
  input  logic        flush,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Decoded instruction codes shared with the R-type decoder.
  localparam logic [7:0] INST_INVALID = 8'h00;
  localparam logic [7:0] INST_MULT    = 8'h10;
  localparam logic [7:0] INST_MULTU   = 8'h11;
  localparam logic [7:0] INST_DIV     = 8'h12;
  localparam logic [7:0] INST_DIVU    = 8'h13;
  localparam logic [7:0] INST_MADD    = 8'h14;
  localparam logic [7:0] INST_MADDU   = 8'h15;
  localparam logic [7:0] INST_MSUB    = 8'h16;
  localparam logic [7:0] INST_MSUBU   = 8'h17;
  localparam logic [7:0] INST_MTHI    = 8'h18;
  localparam logic [7:0] INST_MTLO    = 8'h19;
  localparam logic [7:0] INST_MUL     = 8'h1A;

  localparam int unsigned CntW = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) : 5;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
  typedef enum logic [1:0] {AccSet, AccAdd, AccSub} acc_e;

  state_e          state_q, state_d;
  acc_e            acc_q, acc_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sgn_q, sgn_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d, nowr_q, nowr_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic            mul_signed, div_signed;
  logic [63:0]     mul_a, mul_b, product, mul_res;
  logic [32:0]     rem_shift, rem_diff;
  logic            q_bit;
  logic [31:0]     quot, remv;

  assign mul_signed = (inst == INST_MULT) || (inst == INST_MADD) || (inst == INST_MSUB);
  assign div_signed = (inst == INST_DIV);

  assign mul_a   = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b   = {{32{sgn_q & b_q[31]}}, b_q};
  assign product = mul_a * mul_b;

  always_comb begin
    case (acc_q)
      AccAdd:  mul_res = {hi_q, lo_q} + product;
      AccSub:  mul_res = {hi_q, lo_q} - product;
      default: mul_res = product;
    endcase
  end

  // a_q shifts out dividend bits from the top and collects quotient bits at the bottom.
  assign rem_shift = {rem_q, a_q[31]};
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign q_bit     = ~rem_diff[32];
  assign quot      = q_neg_q ? -a_q : a_q;
  assign remv      = r_neg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    nowr_d  = nowr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid && !flush) begin
          case (inst)
            INST_MTHI: hi_d = operand_a;
            INST_MTLO: lo_d = operand_a;
            INST_MULT, INST_MULTU, INST_MADD, INST_MADDU, INST_MSUB, INST_MSUBU: begin
              state_d = StMul;
              cnt_d   = CntW'(MUL_CYCLES - 1);
              a_d     = operand_a;
              b_d     = operand_b;
              sgn_d   = mul_signed;
              if ((inst == INST_MADD) || (inst == INST_MADDU))      acc_d = AccAdd;
              else if ((inst == INST_MSUB) || (inst == INST_MSUBU)) acc_d = AccSub;
              else                                                  acc_d = AccSet;
            end
            INST_DIV, INST_DIVU: begin
              q_neg_d = div_signed & (operand_a[31] ^ operand_b[31]);
              r_neg_d = div_signed & operand_a[31];
              a_d     = (div_signed && operand_a[31]) ? -operand_a : operand_a;
              b_d     = (div_signed && operand_b[31]) ? -operand_b : operand_b;
              rem_d   = '0;
              cnt_d   = CntW'(31);
              nowr_d  = (operand_b == '0);
              state_d = (operand_b == '0) ? StFix : StDiv;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          rem_d = q_bit ? rem_diff[31:0] : rem_shift[31:0];
          a_d   = {a_q[30:0], q_bit};
          if (cnt_q == '0) state_d = StFix;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          if (!nowr_q) begin
            lo_d = quot;
            hi_d = remv;
          end
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= AccSet;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      nowr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      nowr_q  <= nowr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed cases plus randomized ops against an arithmetic HI/LO model.
module tb_ex_muldiv;

  localparam int unsigned MC = 2;

  localparam logic [7:0] I_INVALID = 8'h00;
  localparam logic [7:0] I_MULT    = 8'h10;
  localparam logic [7:0] I_MULTU   = 8'h11;
  localparam logic [7:0] I_DIV     = 8'h12;
  localparam logic [7:0] I_DIVU    = 8'h13;
  localparam logic [7:0] I_MADD    = 8'h14;
  localparam logic [7:0] I_MADDU   = 8'h15;
  localparam logic [7:0] I_MSUB    = 8'h16;
  localparam logic [7:0] I_MSUBU   = 8'h17;
  localparam logic [7:0] I_MTHI    = 8'h18;
  localparam logic [7:0] I_MTLO    = 8'h19;
  localparam logic [7:0] I_MUL     = 8'h1A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  inst;
  logic        op_valid, flush;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  ex_muldiv #(.MUL_CYCLES(MC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .op_valid  (op_valid),
    .flush     (flush),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted op; lat is the expected number of busy cycles.
  task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {m_hi, m_lo};
    lat = 0;
    if (op == I_MULT || op == I_MADD || op == I_MSUB) p = 64'(sa * sb);
    else                                              p = {32'b0, a} * {32'b0, b};
    case (op)
      I_MTHI: m_hi = a;
      I_MTLO: m_lo = a;
      I_MULT, I_MULTU: begin {m_hi, m_lo} = p;       lat = MC; end
      I_MADD, I_MADDU: begin {m_hi, m_lo} = acc + p; lat = MC; end
      I_MSUB, I_MSUBU: begin {m_hi, m_lo} = acc - p; lat = MC; end
      I_DIV: begin
        lat = (b == 0) ? 1 : 33;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      I_DIVU: begin
        lat = (b == 0) ? 1 : 33;
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, cyc, dn;
    model(op, a, b, lat);
    @(negedge clk);
    inst = op; operand_a = a; operand_b = b; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; inst = I_INVALID;
    cyc = 0;
    dn  = int'(done);
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
      dn += int'(done);
    end
    check_eq($sformatf("busy_cycles op=%0h", op), 64'(cyc), 64'(lat));
    check_eq($sformatf("done_pulses op=%0h", op), 64'(dn), (lat > 0) ? 64'd1 : 64'd0);
    check_eq($sformatf("hi op=%0h", op), {32'b0, hi}, {32'b0, m_hi});
    check_eq($sformatf("lo op=%0h", op), {32'b0, lo}, {32'b0, m_lo});
  endtask

  logic [7:0] op_tab [12] = '{I_MULT, I_MULTU, I_DIV, I_DIVU, I_MADD, I_MADDU,
                              I_MSUB, I_MSUBU, I_MTHI, I_MTLO, I_MUL, I_INVALID};

  initial begin
    logic [31:0] ra, rb;
    int          sel;
    rst_n = 1'b0; inst = I_INVALID; op_valid = 1'b0; flush = 1'b0;
    operand_a = '0; operand_b = '0;
    #12;
    check_eq("reset_hi",   {32'b0, hi}, 64'd0);
    check_eq("reset_lo",   {32'b0, lo}, 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(I_MTHI, 32'h12345678, 32'h0);
    run_op(I_MTLO, 32'h9ABCDEF0, 32'h0);
    check_eq("mthi_val", {32'b0, hi}, 64'h12345678);
    check_eq("mtlo_val", {32'b0, lo}, 64'h9ABCDEF0);
    #2 rst_n = 1'b0; #1;
    check_eq("async_rst_hi", {32'b0, hi}, 64'd0);
    check_eq("async_rst_lo", {32'b0, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst_n = 1'b1;

    run_op(I_MULT, 32'hFFFFFFFE, 32'd3);
    check_eq("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_op(I_MULTU, 32'hFFFFFFFE, 32'd3);
    check_eq("multu_hilo", {hi, lo}, 64'h00000002_FFFFFFFA);
    run_op(I_DIV, 32'hFFFFFFF9, 32'd2);
    check_eq("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(I_DIVU, 32'd7, 32'd2);
    check_eq("divu_7_2", {hi, lo}, 64'h00000001_00000003);
    run_op(I_DIV, 32'h80000000, 32'hFFFFFFFF);
    check_eq("div_ovf", {hi, lo}, 64'h00000000_80000000);

    run_op(I_MTHI, 32'd0, 32'd0);
    run_op(I_MTLO, 32'd5, 32'd0);
    run_op(I_MADDU, 32'hFFFFFFFF, 32'd2);
    check_eq("maddu", {hi, lo}, 64'h00000002_00000003);
    run_op(I_MSUB, 32'd1, 32'd1);
    check_eq("msub", {hi, lo}, 64'h00000002_00000002);
    run_op(I_MTHI, 32'd0, 32'd0);
    run_op(I_MTLO, 32'd0, 32'd0);
    run_op(I_MSUBU, 32'd1, 32'd1);
    check_eq("msubu_wrap", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);

    run_op(I_MTHI, 32'hAA, 32'd0);
    run_op(I_MTLO, 32'hBB, 32'd0);
    run_op(I_DIV, 32'd9, 32'd0);
    check_eq("div0_keep", {hi, lo}, 64'h000000AA_000000BB);

    // Flush ten cycles into a divide.
    @(negedge clk);
    inst = I_DIV; operand_a = 32'd100; operand_b = 32'd7; op_valid = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_done", 64'(done), 64'd0);
    @(negedge clk); flush = 1'b0;
    @(posedge clk); #1;
    check_eq("flush_done_after", 64'(done), 64'd0);
    check_eq("flush_hilo", {hi, lo}, {m_hi, m_lo});

    // Flush blocks an IDLE move.
    @(negedge clk);
    flush = 1'b1; op_valid = 1'b1; inst = I_MTLO; operand_a = 32'h55;
    @(posedge clk); #1;
    check_eq("flush_mtlo_lo", {32'b0, lo}, {32'b0, m_lo});
    check_eq("flush_mtlo_busy", 64'(busy), 64'd0);
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; inst = I_INVALID;

    // Reset in the middle of a multiply.
    @(negedge clk);
    inst = I_MULT; operand_a = 32'd6; operand_b = 32'd7; op_valid = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0;
    check_eq("mul_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0; #1;
    check_eq("midmul_rst_busy", 64'(busy), 64'd0);
    check_eq("midmul_rst_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("midmul_rst_done", 64'(done), 64'd0);

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = rb & 32'hFF;
        default: ;
      endcase
      run_op(op_tab[sel], ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
